axi4_wch_dropper: RTL and testbench
===================================

AXI4_WCH_DROPPER -- requirements
Module: axi4_wch_dropper

Interface
REQ-001 SHALL have parameter C_AXI_DATA_WIDTH, default 64, meaning W data width in bits.
REQ-002 SHALL have parameter C_AXI_USER_WIDTH, default 4, meaning W user width in bits.
REQ-003 SHALL have parameter C_DEPTH, default 4, meaning decision-queue entries (power of 2, >=2).
REQ-004 SHALL have port axi4_aclk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 SHALL have port axi4_arst, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port trans_accept, input, 1, meaning the address stage accepted a write burst.
REQ-007 SHALL have port trans_drop, input, 1, meaning the address stage dropped a write burst.
REQ-008 SHALL have port trans_len, input, 8, meaning AWLEN of that burst (beats minus 1).
REQ-009 SHALL have port trans_ready, output, 1, meaning the decision queue is not full.
REQ-010 SHALL have ports s_axi4_wdata/wstrb/wuser/wlast/wvalid, inputs, DATA/DATA/8/USER/1/1, meaning slave-side W channel.
REQ-011 SHALL have port s_axi4_wready, output, 1, meaning slave-side W ready.
REQ-012 SHALL have ports m_axi4_wdata/wstrb/wuser/wlast/wvalid, outputs, same widths, meaning master-side W channel.
REQ-013 SHALL have port m_axi4_wready, input, 1, meaning master-side W ready.
REQ-014 SHALL have port drop_done, output, 1, meaning one-cycle pulse: last beat of a dropped burst sunk.
REQ-015 SHALL have port err_len, output, 1, meaning one-cycle pulse: wlast beat index differed from trans_len.

Function
REQ-016 SHALL push {drop, len} into the queue when (trans_accept|trans_drop) & trans_ready; drop = trans_drop (drop wins if both high).
REQ-017 SHALL ignore decisions presented while trans_ready=0 (upstream holds them).
REQ-018 SHALL run an FSM IDLE/PASS/DROP; IDLE -> PASS or DROP on the cycle after queue non-empty, per head drop bit.
REQ-019 In IDLE SHALL drive s_axi4_wready=0 and m_axi4_wvalid=0; no fall-through: a decision pushed in cycle N governs beats from cycle N+1.
REQ-020 In PASS SHALL connect W combinationally: m_wvalid=s_wvalid, s_wready=m_wready, data/strb/user/last copied; zero latency.
REQ-021 In DROP SHALL drive s_axi4_wready=1, m_axi4_wvalid=0, m_axi4_w* payload 0.
REQ-022 SHALL count handshaken beats in an 8-bit counter, cleared at burst end, saturating at 255.
REQ-023 SHALL end a burst only on a handshaken beat with s_axi4_wlast=1: pop queue, clear counter, go to IDLE, or directly to PASS/DROP if another entry is queued.
REQ-024 SHALL pulse err_len on the wlast beat when counter != head len; burst still ends there (early and late wlast alike).
REQ-025 SHALL pulse drop_done in the cycle of the wlast handshake while in DROP.
REQ-026 SHALL allow push and pop in the same cycle; occupancy unchanged, full queue stays full, trans_ready stays 0.
REQ-027 SHALL keep trans_ready = ~full, registered from occupancy, never combinational from inputs.

Reset
REQ-028 On axi4_arst=1 at a clock edge SHALL empty queue, clear counter, enter IDLE, drive trans_ready=0, s_axi4_wready=0, m_axi4_wvalid=0, drop_done=0, err_len=0.
REQ-029 SHALL raise trans_ready on the first edge after reset deasserts; a burst mid-transfer at reset is abandoned with no pulse.

Structure
REQ-030 SHALL place the FSM state encoding and C_DEPTH default in the shared package axi_rab_pkg.
REQ-031 SHALL implement the decision queue as sub-module axi4_wch_dropper_fifo (sync active-high reset, width 9).
REQ-032 SHALL keep all W payload paths free of registers; only control is registered.

Verification
REQ-033 SHALL test accept len=3, 4 beats with m_wready=1 -> 4 beats out unchanged, m_wlast on beat 4, no pulses.
REQ-034 SHALL test drop len=1, 2 beats -> s_wready=1 both cycles, m_wvalid=0, drop_done pulses on beat 2.
REQ-035 SHALL test 4 decisions with W held off -> trans_ready=0 after the 4th, 5th ignored; one pop re-raises it next cycle.
REQ-036 SHALL test accept len=3 with wlast on beat 2 -> err_len pulses on beat 2, next queued burst starts on the next beat.
REQ-037 SHALL test a push while full and a pop in the same cycle -> occupancy stays 4, order preserved.
REQ-038 SHALL test reset asserted mid-drop burst -> all outputs at reset values next cycle, queue empty, no drop_done.

Source files
------------

// File: rtl/axi_rab_pkg.sv
// Shared definitions for the AXI RAB W-channel dropper: FSM encoding,
// decision-queue entry layout and default queue depth.
package axi_rab_pkg;

  localparam int unsigned C_DEPTH_DEFAULT = 4;
  localparam int unsigned WCH_DEC_WIDTH   = 9;

  typedef enum logic [1:0] {
    WCH_IDLE = 2'd0,
    WCH_PASS = 2'd1,
    WCH_DROP = 2'd2
  } wch_state_e;

  typedef struct packed {
    logic       drop;
    logic [7:0] len;
  } wch_decision_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/axi4_wch_dropper_fifo.sv
// Decision queue for the W-channel dropper: synchronous FIFO with registered
// status flags and a look-ahead view of the entry behind the head.
module axi4_wch_dropper_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [WIDTH-1:0] second,
  output logic             empty,
  output logic             full,
  output logic             two_plus,
  output logic             ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             do_push;
  logic             do_pop;

  // A full queue may accept a new entry in the same cycle it retires one.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    count_nxt = count;
    unique case ({do_push, do_pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      two_plus <= 1'b0;
      ready    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      empty    <= (count_nxt == '0);
      full     <= (count_nxt == DEPTH_C);
      two_plus <= (count_nxt >= CW'(2));
      ready    <= (count_nxt != DEPTH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head   = mem[rd_ptr];
  assign second = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/axi4_wch_dropper.sv
// AXI4 W-channel dropper: forwards or sinks write-data bursts in the order the
// address stage decided, with zero-latency pass-through of the W payload.
module axi4_wch_dropper
  import axi_rab_pkg::*;
#(
  parameter int unsigned C_AXI_DATA_WIDTH = 64,
  parameter int unsigned C_AXI_USER_WIDTH = 4,
  parameter int unsigned C_DEPTH          = C_DEPTH_DEFAULT
) (
  input  logic                          axi4_aclk,
  input  logic                          axi4_arst,
  input  logic                          trans_accept,
  input  logic                          trans_drop,
  input  logic [7:0]                    trans_len,
  output logic                          trans_ready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   s_axi4_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] s_axi4_wstrb,
  input  logic [C_AXI_USER_WIDTH-1:0]   s_axi4_wuser,
  input  logic                          s_axi4_wlast,
  input  logic                          s_axi4_wvalid,
  output logic                          s_axi4_wready,
  output logic [C_AXI_DATA_WIDTH-1:0]   m_axi4_wdata,
  output logic [C_AXI_DATA_WIDTH/8-1:0] m_axi4_wstrb,
  output logic [C_AXI_USER_WIDTH-1:0]   m_axi4_wuser,
  output logic                          m_axi4_wlast,
  output logic                          m_axi4_wvalid,
  input  logic                          m_axi4_wready,
  output logic                          drop_done,
  output logic                          err_len
);

  wch_state_e    state;
  wch_state_e    follow_state;
  logic [7:0]    beat_cnt;
  logic [WCH_DEC_WIDTH-1:0] head_raw;
  logic [WCH_DEC_WIDTH-1:0] second_raw;
  wch_decision_t head_dec;
  wch_decision_t second_dec;
  wch_decision_t push_dec;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_two;
  logic          fifo_ready;
  logic          push_ok;
  logic          beat_hs;
  logic          burst_end;
  logic          follow_valid;
  logic          follow_drop;

  assign head_dec   = wch_decision_t'(head_raw);
  assign second_dec = wch_decision_t'(second_raw);
  assign push_dec   = '{drop: trans_drop, len: trans_len};

  assign trans_ready = fifo_ready;
  assign beat_hs     = s_axi4_wvalid & s_axi4_wready;
  assign burst_end   = beat_hs & s_axi4_wlast;
  assign push_ok     = (trans_accept | trans_drop) & (fifo_ready | (burst_end & fifo_full));

  axi4_wch_dropper_fifo #(
    .WIDTH (WCH_DEC_WIDTH),
    .DEPTH (C_DEPTH)
  ) u_fifo (
    .clk       (axi4_aclk),
    .rst       (axi4_arst),
    .push      (push_ok),
    .push_data (push_dec),
    .pop       (burst_end),
    .head      (head_raw),
    .second    (second_raw),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .two_plus  (fifo_two),
    .ready     (fifo_ready)
  );

  // The burst that follows is the queued head when idle, or the entry behind
  // the head at burst end; either way a same-cycle push fills an empty slot.
  always_comb begin
    follow_valid = 1'b0;
    follow_drop  = 1'b0;
    if (state == WCH_IDLE) begin
      follow_valid = ~fifo_empty | push_ok;
      follow_drop  = fifo_empty ? trans_drop : head_dec.drop;
    end else begin
      follow_valid = fifo_two | push_ok;
      follow_drop  = fifo_two ? second_dec.drop : trans_drop;
    end
    follow_state = WCH_IDLE;
    if (follow_valid) follow_state = follow_drop ? WCH_DROP : WCH_PASS;
  end

  always_ff @(posedge axi4_aclk) begin
    if (axi4_arst) begin
      state    <= WCH_IDLE;
      beat_cnt <= '0;
    end else begin
      unique case (state)
        WCH_IDLE: state <= follow_state;
        WCH_PASS, WCH_DROP: begin
          if (burst_end) begin
            beat_cnt <= '0;
            state    <= follow_state;
          end else if (beat_hs) begin
            beat_cnt <= sat_inc8(beat_cnt);
          end
        end
        default: state <= WCH_IDLE;
      endcase
    end
  end

  always_comb begin
    s_axi4_wready = 1'b0;
    m_axi4_wvalid = 1'b0;
    m_axi4_wdata  = '0;
    m_axi4_wstrb  = '0;
    m_axi4_wuser  = '0;
    m_axi4_wlast  = 1'b0;
    unique case (state)
      WCH_PASS: begin
        s_axi4_wready = m_axi4_wready;
        m_axi4_wvalid = s_axi4_wvalid;
        m_axi4_wdata  = s_axi4_wdata;
        m_axi4_wstrb  = s_axi4_wstrb;
        m_axi4_wuser  = s_axi4_wuser;
        m_axi4_wlast  = s_axi4_wlast;
      end
      WCH_DROP: s_axi4_wready = 1'b1;
      default:  s_axi4_wready = 1'b0;
    endcase
  end

  assign drop_done = burst_end & (state == WCH_DROP) & ~axi4_arst;
  assign err_len   = burst_end & (beat_cnt != head_dec.len) & ~axi4_arst;

endmodule

// File: tb/tb_axi4_wch_dropper.sv
// Directed bench for axi4_wch_dropper: a queue-level reference model checked
// every cycle, plus hand-computed spot checks at the interesting beats.
module tb_axi4_wch_dropper;

  localparam int unsigned DW = 64;
  localparam int unsigned UW = 4;
  localparam int unsigned DEPTH = 4;

  logic          clk;
  logic          arst;
  logic          trans_accept;
  logic          trans_drop;
  logic [7:0]    trans_len;
  logic          trans_ready;
  logic [DW-1:0] s_wdata;
  logic [DW/8-1:0] s_wstrb;
  logic [UW-1:0] s_wuser;
  logic          s_wlast;
  logic          s_wvalid;
  logic          s_wready;
  logic [DW-1:0] m_wdata;
  logic [DW/8-1:0] m_wstrb;
  logic [UW-1:0] m_wuser;
  logic          m_wlast;
  logic          m_wvalid;
  logic          m_wready;
  logic          drop_done;
  logic          err_len;

  int checks = 0;
  int failures = 0;
  bit mon_on = 0;
  bit done = 0;

  axi4_wch_dropper #(
    .C_AXI_DATA_WIDTH (DW),
    .C_AXI_USER_WIDTH (UW),
    .C_DEPTH          (DEPTH)
  ) dut (
    .axi4_aclk     (clk),
    .axi4_arst     (arst),
    .trans_accept  (trans_accept),
    .trans_drop    (trans_drop),
    .trans_len     (trans_len),
    .trans_ready   (trans_ready),
    .s_axi4_wdata  (s_wdata),
    .s_axi4_wstrb  (s_wstrb),
    .s_axi4_wuser  (s_wuser),
    .s_axi4_wlast  (s_wlast),
    .s_axi4_wvalid (s_wvalid),
    .s_axi4_wready (s_wready),
    .m_axi4_wdata  (m_wdata),
    .m_axi4_wstrb  (m_wstrb),
    .m_axi4_wuser  (m_wuser),
    .m_axi4_wlast  (m_wlast),
    .m_axi4_wvalid (m_wvalid),
    .m_axi4_wready (m_wready),
    .drop_done     (drop_done),
    .err_len       (err_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    return 64'hC0DE_0000_0000_0000 | 64'(i);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    arst = 1'b0;
    trans_accept = 1'b0;
    trans_drop = 1'b0;
    trans_len = 8'd0;
    s_wvalid = 1'b0;
    s_wlast = 1'b0;
    s_wdata = '0;
    s_wstrb = '0;
    s_wuser = '0;
    m_wready = 1'b1;
  endtask

  task automatic beat(input int i, input bit last);
    s_wvalid = 1'b1;
    s_wdata = pat(i);
    s_wstrb = 8'(i * 3);
    s_wuser = 4'(i);
    s_wlast = last;
  endtask

  // Reference model: decisions queued in order; the head governs W from the
  // cycle after it is queued; trans_ready reflects occupancy after each edge.
  bit [8:0] mq[$];
  int m_idx = 0;
  bit m_rdy = 1'b0;

  initial begin
    while (!done) begin
      @(negedge clk);
      if (mon_on && !done) begin
        bit act, is_drop, e_swr, e_mv, hs, fin, e_dd, e_el, pushed;
        bit [8:0] hd;
        logic [127:0] e_pay;
        act = (mq.size() > 0);
        hd = act ? mq[0] : 9'd0;
        is_drop = hd[8];
        e_swr = act ? (is_drop ? 1'b1 : m_wready) : 1'b0;
        e_mv = (act && !is_drop) ? s_wvalid : 1'b0;
        e_pay = (act && !is_drop) ? 128'({s_wdata, s_wstrb, s_wuser, s_wlast}) : 128'd0;
        hs = s_wvalid & e_swr;
        fin = hs & s_wlast;
        e_dd = fin & is_drop & !arst;
        e_el = fin & (m_idx != int'(hd[7:0])) & !arst;
        chk("mon_trans_ready", 128'(trans_ready), 128'(m_rdy));
        chk("mon_s_wready", 128'(s_wready), 128'(e_swr));
        chk("mon_m_wvalid", 128'(m_wvalid), 128'(e_mv));
        chk("mon_m_payload", 128'({m_wdata, m_wstrb, m_wuser, m_wlast}), e_pay);
        chk("mon_drop_done", 128'(drop_done), 128'(e_dd));
        chk("mon_err_len", 128'(err_len), 128'(e_el));
        if (arst) begin
          mq.delete();
          m_idx = 0;
          m_rdy = 1'b0;
        end else begin
          pushed = (trans_accept | trans_drop) & (m_rdy | (fin && mq.size() == DEPTH));
          if (fin) begin
            void'(mq.pop_front());
            m_idx = 0;
          end else if (hs) begin
            m_idx++;
          end
          if (pushed) mq.push_back({trans_drop, trans_len});
          m_rdy = (mq.size() < DEPTH);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    arst = 1'b1;
    tick();
    mon_on = 1'b1;
    arst = 1'b1;
    tick();
    #1;
    chk("rst_trans_ready", 128'(trans_ready), 128'(0));
    chk("rst_s_wready", 128'(s_wready), 128'(0));
    chk("rst_m_wvalid", 128'(m_wvalid), 128'(0));
    tick(); clr(); #1;
    chk("rel_trans_ready_low", 128'(trans_ready), 128'(0));
    tick(); clr(); #1;
    chk("rel_trans_ready_high", 128'(trans_ready), 128'(1));

    // Pass burst, len=3, four beats
    tick(); clr(); trans_accept = 1'b1; trans_len = 8'd3;
    for (int b = 0; b < 4; b++) begin
      tick(); clr(); beat(b + 1, b == 3); #1;
      if (b == 0) chk("pass_first_wready", 128'(s_wready), 128'(1));
      if (b == 3) begin
        chk("pass_last_wlast", 128'(m_wlast), 128'(1));
        chk("pass_last_wdata", 128'(m_wdata), 128'(pat(4)));
        chk("pass_last_err", 128'(err_len), 128'(0));
      end
    end

    // Drop burst, len=1, downstream stalled to show it is ignored
    tick(); clr(); trans_drop = 1'b1; trans_len = 8'd1;
    tick(); clr(); m_wready = 1'b0; beat(10, 1'b0); #1;
    chk("drop_b1_wready", 128'(s_wready), 128'(1));
    chk("drop_b1_mvalid", 128'(m_wvalid), 128'(0));
    chk("drop_b1_done", 128'(drop_done), 128'(0));
    tick(); clr(); m_wready = 1'b0; beat(11, 1'b1); #1;
    chk("drop_b2_done", 128'(drop_done), 128'(1));
    chk("drop_b2_mvalid", 128'(m_wvalid), 128'(0));
    chk("drop_b2_mdata", 128'(m_wdata), 128'(0));

    // Fill the queue with W held off
    tick(); clr(); trans_accept = 1'b1; trans_len = 8'd0;
    tick(); clr(); trans_accept = 1'b1; trans_drop = 1'b1; trans_len = 8'd0;
    tick(); clr(); trans_accept = 1'b1; trans_len = 8'd3;
    tick(); clr(); trans_accept = 1'b1; trans_len = 8'd0;
    tick(); clr(); trans_accept = 1'b1; trans_len = 8'd5; #1;
    chk("full_trans_ready", 128'(trans_ready), 128'(0));
    // Push while full together with a pop of the pass head
    tick(); clr(); trans_drop = 1'b1; trans_len = 8'd0; beat(20, 1'b1); #1;
    chk("pushpop_ready", 128'(trans_ready), 128'(0));
    chk("pushpop_mvalid", 128'(m_wvalid), 128'(1));
    tick(); clr(); #1;
    chk("pushpop_still_full", 128'(trans_ready), 128'(0));
    chk("next_is_drop", 128'(s_wready), 128'(1));
    tick(); clr(); beat(21, 1'b1); #1;
    chk("e1_drop_done", 128'(drop_done), 128'(1));
    tick(); clr(); #1;
    chk("pop_reraises_ready", 128'(trans_ready), 128'(1));
    // Early wlast on a len=3 pass burst
    tick(); clr(); beat(22, 1'b0);
    tick(); clr(); beat(23, 1'b1); #1;
    chk("early_err_len", 128'(err_len), 128'(1));
    tick(); clr(); beat(24, 1'b1); #1;
    chk("e3_mvalid", 128'(m_wvalid), 128'(1));
    chk("e3_wdata", 128'(m_wdata), 128'(pat(24)));
    chk("e3_err_len", 128'(err_len), 128'(0));
    tick(); clr(); beat(25, 1'b1); #1;
    chk("e4_drop_done", 128'(drop_done), 128'(1));
    tick(); clr(); beat(26, 1'b1); #1;
    chk("idle_wready", 128'(s_wready), 128'(0));

    // Late wlast with a downstream stall
    tick(); clr(); trans_accept = 1'b1; trans_len = 8'd0;
    tick(); clr(); m_wready = 1'b0; beat(30, 1'b0); #1;
    chk("stall_wready", 128'(s_wready), 128'(0));
    tick(); clr(); beat(30, 1'b0);
    tick(); clr(); beat(31, 1'b1); #1;
    chk("late_err_len", 128'(err_len), 128'(1));

    // Reset in the middle of a drop burst
    tick(); clr(); trans_drop = 1'b1; trans_len = 8'd3;
    tick(); clr(); beat(40, 1'b0);
    tick(); clr(); beat(41, 1'b0);
    tick(); clr(); arst = 1'b1; beat(42, 1'b1); #1;
    chk("rstmid_drop_done", 128'(drop_done), 128'(0));
    tick(); clr(); beat(43, 1'b1); #1;
    chk("post_rst_ready", 128'(trans_ready), 128'(0));
    chk("post_rst_wready", 128'(s_wready), 128'(0));
    chk("post_rst_mvalid", 128'(m_wvalid), 128'(0));
    chk("post_rst_done", 128'(drop_done), 128'(0));
    chk("post_rst_err", 128'(err_len), 128'(0));
    tick(); clr(); #1;
    chk("post_rst_ready_up", 128'(trans_ready), 128'(1));
    tick(); clr(); trans_accept = 1'b1; trans_len = 8'd0;
    tick(); clr(); beat(44, 1'b1); #1;
    chk("fresh_pass_mvalid", 128'(m_wvalid), 128'(1));
    chk("fresh_pass_wdata", 128'(m_wdata), 128'(pat(44)));

    tick(); clr();
    tick();
    done = 1'b1;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
